// File: rtl/alu_dispatch_if.sv
// rtl/alu_dispatch_if.sv - command and result handshake bundle for alu_dispatch
// The dispatcher is the slave on both ports; the caller side is the master.
interface alu_dispatch_if #(
    parameter int W     = 65,
    parameter int OPW   = 9,
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [OPW-1:0]   cmd_op;
    logic [W-1:0]     cmd_a;
    logic [W-1:0]     cmd_b;
    logic [TAG_W-1:0] cmd_tag;

    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_data;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, res_ready,
        output cmd_ready, res_valid, res_data, res_tag, res_err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, res_ready,
        input  cmd_ready, res_valid, res_data, res_tag, res_err
    );
endinterface

// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - issue unit for one alu core with error screening and in-order result FIFO
// Two tracking stages mirror the core's registered latency; results land in a credit-protected FIFO.
module alu_dispatch #(
    parameter int W     = 65,
    parameter int OPW   = 9,
    parameter int TAG_W = 4,
    parameter int DEPTH = 4
) (
    input  logic               c,
    input  logic               rst,
    alu_dispatch_if.slave      bus,
    output logic [W-1:0]       alu_a,
    output logic [W-1:0]       alu_b,
    output logic [OPW-1:0]     alu_instr,
    input  logic [W-1:0]       alu_out,
    output logic               busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [OPW-1:0] OP_NOOP = OPW'(128);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(3);
    localparam logic [OPW-1:0] OP_MOD  = OPW'(4);

    logic [W-1:0]     alu_a_q, alu_a_d;
    logic [W-1:0]     alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_instr_q, alu_instr_d;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_err_q, s1_err_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s2_valid_q;
    logic             s2_err_q;
    logic [TAG_W-1:0] s2_tag_q;

    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;

    logic [W-1:0]     mem_data [DEPTH];
    logic [TAG_W-1:0] mem_tag  [DEPTH];
    logic             mem_err  [DEPTH];

    logic [CW:0]      inflight;
    logic             accept, op_legal, zero_div, is_noop, push, pop;

    // Credit counts everything already issued, so the FIFO can never overflow.
    assign inflight      = {1'b0, count_q} + (CW+1)'(s1_valid_q) + (CW+1)'(s2_valid_q);
    assign bus.cmd_ready = !rst && (inflight < (CW+1)'(DEPTH));
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    assign is_noop  = (bus.cmd_op == OP_NOOP);
    assign op_legal = (bus.cmd_op[OPW-1:4] == '0) || is_noop;
    assign zero_div = ((bus.cmd_op == OP_DIV) || (bus.cmd_op == OP_MOD)) && (bus.cmd_b == '0);

    assign push = s2_valid_q;
    assign pop  = bus.res_valid && bus.res_ready;

    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_instr_d = OP_NOOP;
        s1_valid_d  = 1'b0;
        s1_err_d    = 1'b0;
        s1_tag_d    = bus.cmd_tag;
        if (accept && !is_noop) begin
            s1_valid_d = 1'b1;
            if (!op_legal || zero_div) begin
                alu_a_d  = '0;
                alu_b_d  = '0;
                s1_err_d = 1'b1;
            end else begin
                alu_a_d     = bus.cmd_a;
                alu_b_d     = bus.cmd_b;
                alu_instr_d = bus.cmd_op;
            end
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge c) begin
        if (rst) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_instr_q <= OP_NOOP;
            s1_valid_q  <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_err_q    <= 1'b0;
            s2_tag_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_instr_q <= alu_instr_d;
            s1_valid_q  <= s1_valid_d;
            s1_err_q    <= s1_err_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s1_valid_q;
            s2_err_q    <= s1_err_q;
            s2_tag_q    <= s1_tag_q;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q     <= count_d;
        end
    end

    // Storage is not reset; count gates visibility of stale entries.
    always_ff @(posedge c) begin
        if (!rst && push) begin
            mem_data[wr_ptr_q] <= s2_err_q ? '0 : alu_out;
            mem_tag[wr_ptr_q]  <= s2_tag_q;
            mem_err[wr_ptr_q]  <= s2_err_q;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_instr = alu_instr_q;

    assign bus.res_valid = (count_q != '0);
    assign bus.res_data  = mem_data[rd_ptr_q];
    assign bus.res_tag   = mem_tag[rd_ptr_q];
    assign bus.res_err   = mem_err[rd_ptr_q];

    assign busy = s1_valid_q || s2_valid_q || (count_q != '0);
endmodule
